// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and defaults for the memory bus controller.
//   state_t : controller FSM states (IDLE, ACCESS, DONE)
//   op_t    : latched transaction kind (READ, WRITE)
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default bus widths
package mem_bus_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/mem_bus_waitcnt.sv
// mem_bus_waitcnt: loadable 4-bit down-counter with terminal-count flag.
//   clk      : system clock, rising edge
//   reset    : synchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   tc       : terminal count, high while count is zero
module mem_bus_waitcnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: processor-to-RAM bus controller with fixed wait states.
//   A request (mr/mw) sampled in IDLE latches addr/wdata/op, then holds the
//   RAM strobe for WAIT_CYCLES+1 ACCESS cycles, then pulses ready in DONE.
// Parameters: DATA_W, ADDR_W, WAIT_CYCLES (0..15).
// Ports:
//   clk, reset (sync, active-low)
//   mr, mw, addr, wdata          : processor request side
//   rdata, busy, ready           : processor response side
//   mem_addr, mem_wdata, mem_re, mem_we, mem_rdata : RAM side
// Build option MEMBUS_ERR_EN: adds output bus_err; simultaneous mr and mw
//   in IDLE is rejected with a one-cycle ready+bus_err and no RAM access.
//   Without it, simultaneous mr and mw performs a write.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mr,
  input  logic              mw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMBUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t state, state_nxt;
  op_t    op_q;
  logic   accept;
  logic   reject;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_tc;

`ifdef MEMBUS_ERR_EN
  logic err_q;
  assign reject = mr & mw;
`else
  assign reject = 1'b0;
`endif

  mem_bus_waitcnt u_waitcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LD),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (reject) begin
          state_nxt = DONE;
        end else if (mr || mw) begin
          accept    = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_re = (op_q == READ);
        mem_we = (op_q == WRITE);
        // Counter enters ACCESS at WAIT_CYCLES; leaving on zero gives
        // WAIT_CYCLES+1 access cycles.
        if (cnt_tc) begin
          state_nxt = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        op_q      <= mw ? WRITE : READ;
      end
      if ((state == ACCESS) && cnt_tc && (op_q == READ)) begin
        rdata <= mem_rdata;
      end
    end
  end

`ifdef MEMBUS_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && reject;
    end
  end

  assign bus_err = (state == DONE) && err_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed bench for mem_bus_ctrl.
//   dut  : WAIT_CYCLES=2 (write, read, ignore-during-access, conflict, reset abort)
//   dut0 : WAIT_CYCLES=0 (back-to-back reads with a held request)
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        reset;

  logic        mr, mw;
  logic [15:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        busy, ready, mem_re, mem_we;

  logic        mr0, mw0;
  logic [15:0] addr0, wdata0, rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        busy0, ready0, mem_re0, mem_we0;

`ifdef MEMBUS_ERR_EN
  logic        bus_err, bus_err0;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mr        (mr),
    .mw        (mw),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef MEMBUS_ERR_EN
    ,
    .bus_err   (bus_err)
`endif
  );

  mem_bus_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .mr        (mr0),
    .mw        (mw0),
    .addr      (addr0),
    .wdata     (wdata0),
    .rdata     (rdata0),
    .busy      (busy0),
    .ready     (ready0),
    .mem_addr  (mem_addr0),
    .mem_wdata (mem_wdata0),
    .mem_re    (mem_re0),
    .mem_we    (mem_we0),
    .mem_rdata (mem_rdata0)
`ifdef MEMBUS_ERR_EN
    ,
    .bus_err   (bus_err0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic rdy_pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic re_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b0;
    mr = 1'b0; mw = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;
    mr0 = 1'b0; mw0 = 1'b0; addr0 = '0; wdata0 = '0; mem_rdata0 = '0;

    // Reset state
    tick(); tick();
    check("rst_busy",   busy,      0);
    check("rst_ready",  ready,     0);
    check("rst_re",     mem_re,    0);
    check("rst_we",     mem_we,    0);
    check("rst_rdata",  rdata,     0);
    check("rst_addr",   mem_addr,  0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst0_busy",  busy0,     0);
`ifdef MEMBUS_ERR_EN
    check("rst_buserr", bus_err,   0);
`endif
    reset = 1'b1;
    tick();

    // Single write, one-cycle mw pulse
    mw = 1'b1; addr = 16'h0010; wdata = 16'hBEEF;
    tick();
    mw = 1'b0; addr = 16'hFFFF; wdata = 16'h0000;
    check("wr_a1_we",    mem_we,    1);
    check("wr_a1_re",    mem_re,    0);
    check("wr_a1_busy",  busy,      1);
    check("wr_a1_addr",  mem_addr,  16'h0010);
    check("wr_a1_wdata", mem_wdata, 16'hBEEF);
    check("wr_a1_ready", ready,     0);
    tick();
    check("wr_a2_we",    mem_we,    1);
    check("wr_a2_addr",  mem_addr,  16'h0010);
    tick();
    check("wr_a3_we",    mem_we,    1);
    check("wr_a3_ready", ready,     0);
    tick();
    check("wr_done_ready", ready,   1);
    check("wr_done_busy",  busy,    0);
    check("wr_done_we",    mem_we,  0);
    tick();
    check("wr_idle_ready", ready,     0);
    check("wr_idle_addr",  mem_addr,  16'h0010);
    check("wr_idle_wdata", mem_wdata, 16'hBEEF);

    // Read; capture only on the last access cycle
    mr = 1'b1; addr = 16'h0010;
    tick();
    mr = 1'b0; mem_rdata = 16'h1111;
    check("rd_a1_re",    mem_re, 1);
    check("rd_a1_we",    mem_we, 0);
    check("rd_a1_rdata", rdata,  0);
    tick();
    mem_rdata = 16'h2222;
    tick();
    mem_rdata = 16'hBEEF;
    check("rd_a3_re", mem_re, 1);
    tick();
    mem_rdata = 16'h0000;
    check("rd_done_ready", ready, 1);
    check("rd_done_rdata", rdata, 16'hBEEF);
    tick();

    // Later write leaves rdata alone
    mw = 1'b1; addr = 16'h0030; wdata = 16'h1234;
    tick();
    mw = 1'b0;
    tick(); tick(); tick();
    check("wr2_done_ready", ready, 1);
    check("wr2_done_rdata", rdata, 16'hBEEF);
    tick();
    check("wr2_idle_addr",  mem_addr, 16'h0030);
    check("wr2_idle_rdata", rdata,    16'hBEEF);

    // Request raised during ACCESS is ignored if gone by IDLE
    mw = 1'b1; addr = 16'h0020; wdata = 16'h5555;
    tick();
    mw = 1'b0; mr = 1'b1; addr = 16'h0040;
    tick();
    check("ign_a2_we",   mem_we,   1);
    check("ign_a2_re",   mem_re,   0);
    check("ign_a2_addr", mem_addr, 16'h0020);
    tick();
    mr = 1'b0;
    tick();
    check("ign_done_ready", ready, 1);
    tick();
    check("ign_idle_ready", ready, 0);
    check("ign_idle_busy",  busy,  0);
    tick();
    check("ign_idle2_busy", busy,   0);
    check("ign_idle2_re",   mem_re, 0);
    check("ign_idle2_rdy",  ready,  0);

    // Simultaneous mr and mw
    mr = 1'b1; mw = 1'b1; addr = 16'h0060; wdata = 16'h0F0F;
    tick();
    mr = 1'b0; mw = 1'b0;
`ifdef MEMBUS_ERR_EN
    check("err_ready",  ready,   1);
    check("err_buserr", bus_err, 1);
    check("err_we",     mem_we,  0);
    check("err_re",     mem_re,  0);
    check("err_busy",   busy,    0);
    check("err_rdata",  rdata,   16'hBEEF);
    tick();
    check("err_idle_buserr", bus_err,  0);
    check("err_idle_ready",  ready,    0);
    check("err_idle_addr",   mem_addr, 16'h0020);
`else
    check("both_we",    mem_we,    1);
    check("both_re",    mem_re,    0);
    check("both_addr",  mem_addr,  16'h0060);
    check("both_wdata", mem_wdata, 16'h0F0F);
    tick(); tick(); tick();
    check("both_done_ready", ready, 1);
    check("both_done_rdata", rdata, 16'hBEEF);
    tick();
`endif

    // WAIT_CYCLES=0, mr held for six cycles
    mr0 = 1'b1; addr0 = 16'h0070; mem_rdata0 = 16'h00C3;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) mr0 = 1'b0;
      check($sformatf("b2b_ready_%0d", i), ready0,  rdy_pat[i]);
      check($sformatf("b2b_re_%0d", i),    mem_re0, re_pat[i]);
    end
    check("b2b_addr",  mem_addr0, 16'h0070);
    check("b2b_rdata", rdata0,    16'h00C3);
    tick();
    check("b2b_end_busy", busy0, 0);

    // Reset on the second ACCESS cycle of a read aborts it
    mr = 1'b1; addr = 16'h0050; mem_rdata = 16'hAAAA;
    tick();
    mr = 1'b0;
    tick();
    check("abort_a2_re",   mem_re, 1);
    check("abort_a2_busy", busy,   1);
    reset = 1'b0;
    tick();
    check("abort_re",    mem_re,   0);
    check("abort_busy",  busy,     0);
    check("abort_rdata", rdata,    0);
    check("abort_ready", ready,    0);
    check("abort_addr",  mem_addr, 0);
    reset = 1'b1;
    tick();
    check("abort_post1_ready", ready, 0);
    check("abort_post1_busy",  busy,  0);
    tick();
    check("abort_post2_ready", ready, 0);
    check("abort_post2_rdata", rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
